// File: rtl/laser_cover_score.sv
// laser_cover_score: snoops a point stream, then scores the engine's two
// reported circle centres by counting the stored points that fall inside
// at least one radius circle.
//
// state  | meaning
// LOAD   | capture IN_VALID points into the buffer until NPTS are held
// WAIT   | buffer full, waiting for the first DONE cycle to latch centres
// SCAN   | one stored point per cycle, accumulating the covered count
// REPORT | publish the count on SCORE with a one-cycle SCORE_VALID
module laser_cover_score #(
  parameter int NPTS = 40,
  parameter int CW   = 4,
  parameter int R_SQ = 16,
  parameter int SW   = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          DONE,
  input  logic [CW-1:0] C1X,
  input  logic [CW-1:0] C1Y,
  input  logic [CW-1:0] C2X,
  input  logic [CW-1:0] C2Y,
  output logic [SW-1:0] SCORE,
  output logic          SCORE_VALID,
  output logic          BUSY
);

  localparam int PW = $clog2(NPTS);
  localparam logic [PW-1:0] LAST   = PW'(NPTS - 1);
  localparam logic [2*CW:0] R_SQ_V = (2*CW+1)'(R_SQ);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_SCAN, S_REPORT} state_t;

  state_t state, state_nxt;

  logic [PW-1:0]   wr_ptr, idx;
  logic [SW-1:0]   acc;
  logic [CW-1:0]   c1x_q, c1y_q, c2x_q, c2y_q;
  logic [2*CW-1:0] pbuf [NPTS];

  logic [CW-1:0] px, py;
  logic [2*CW:0] d1_sq, d2_sq;
  logic          covered;

  // |a-b| without wrap: subtract the smaller from the larger
  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Full-precision squared distance; one extra bit so the sum never wraps
  function automatic logic [2*CW:0] dist_sq(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
    logic [2*CW-1:0] sx, sy;
    sx = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  // Buffer-read / distance / compare chain for the point at idx
  always_comb begin
    {px, py} = pbuf[idx];
    d1_sq    = dist_sq(abs_diff(px, c1x_q), abs_diff(py, c1y_q));
    d2_sq    = dist_sq(abs_diff(px, c2x_q), abs_diff(py, c2y_q));
    covered  = (d1_sq <= R_SQ_V) | (d2_sq <= R_SQ_V);
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_LOAD;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (IN_VALID && (wr_ptr == LAST)) state_nxt = S_WAIT;
      S_WAIT:   if (DONE) state_nxt = S_SCAN;
      S_SCAN:   if (idx == LAST) state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // BUSY covers the window where the checker is committed to a pattern
  always_comb begin
    BUSY = (state == S_WAIT) || (state == S_SCAN);
  end

  // Point buffer; contents are don't-care after reset so no reset here
  always_ff @(posedge CLK) begin
    if ((state == S_LOAD) && IN_VALID) pbuf[wr_ptr] <= {X, Y};
  end

  // Pointers, latched centres, accumulator and published score
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr      <= '0;
      idx         <= '0;
      acc         <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
    end else begin
      SCORE_VALID <= (state == S_REPORT);
      case (state)
        S_LOAD: begin
          if (IN_VALID) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        end
        S_WAIT: begin
          if (DONE) begin
            c1x_q <= C1X;
            c1y_q <= C1Y;
            c2x_q <= C2X;
            c2y_q <= C2Y;
            acc   <= '0;
            idx   <= '0;
          end
        end
        S_SCAN: begin
          acc <= acc + SW'(covered);
          idx <= (idx == LAST) ? '0 : idx + PW'(1);
        end
        S_REPORT: begin
          SCORE  <= acc;
          wr_ptr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
